// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: arbiter FSM encoding and width helpers shared by fifo_wr_arbiter and rr_pick
package fifo_arb_pkg;
  typedef enum logic {ARB = 1'b0, OWN = 1'b1} arb_state_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick; req/ptr in, one-hot grant and its index out (first set req at or after ptr)
module rr_pick import fifo_arb_pkg::*; #(
  parameter int N = 4
) (
  input  logic [N-1:0]          req,
  input  logic [idx_w(N)-1:0]   ptr,
  output logic [N-1:0]          grant,
  output logic [idx_w(N)-1:0]   idx
);
  localparam int IW = idx_w(N);
  function automatic logic [IW-1:0] wrap(input int v);
    return IW'((v >= N) ? v - N : v);
  endfunction
  always_comb begin
    grant = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[wrap(int'(ptr) + k)]) begin
        grant = N'(1) << wrap(int'(ptr) + k);
        idx = wrap(int'(ptr) + k);
      end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter onto one FIFO write port; Req/Data in, Grant out, registered Wr_Req/Data_in/Grant_Idx, credit from Rd_Req/Empty, sticky Ovf_Err on Wr_Req&Full
module fifo_wr_arbiter import fifo_arb_pkg::*; #(
  parameter int FIFO_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int BURST_MAX  = 4
) (
  input  logic                          CLK,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            Req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] Data,
  output logic [NUM_REQ-1:0]            Grant,
  output logic [idx_w(NUM_REQ)-1:0]     Grant_Idx,
  output logic                          Wr_Req,
  output logic [FIFO_WIDTH-1:0]         Data_in,
  input  logic                          Rd_Req,
  input  logic                          Empty,
  input  logic                          Full,
  output logic                          Ovf_Err
);
  localparam int IW = idx_w(NUM_REQ);
  localparam int BW = cnt_w(BURST_MAX);
  localparam int CW = cnt_w(FIFO_DEPTH);
  arb_state_t state, state_n;
  logic [IW-1:0] ptr, ptr_n, owner, owner_n, pick_idx, win;
  logic [BW-1:0] beats, beats_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [NUM_REQ-1:0] pick_grant;
  logic [FIFO_WIDTH-1:0] win_data;
  logic credit_ok, accept, pop, last_beat;
  rr_pick #(.N(NUM_REQ)) u_pick (
    .req  (Req),
    .ptr  (ptr),
    .grant(pick_grant),
    .idx  (pick_idx)
  );
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == IW'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction
  always_comb begin
    credit_ok = cnt < CW'(FIFO_DEPTH);
    win = (state == OWN) ? owner : pick_idx;
    Grant = (!rst_n || !credit_ok) ? '0 : (state == OWN) ? ((NUM_REQ'(1) << owner) & Req) : pick_grant;
    accept = |(Grant & Req);
    pop = Rd_Req & ~Empty;
    last_beat = (beats + 1'b1) == BW'(BURST_MAX);
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (IW'(i) == win) win_data = Data[i*FIFO_WIDTH +: FIFO_WIDTH];
  end
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    owner_n = owner;
    beats_n = beats;
    if (state == ARB) begin
      if (accept && BURST_MAX == 1) ptr_n = next_idx(pick_idx);
      else if (accept) begin
        state_n = OWN;
        owner_n = pick_idx;
        beats_n = BW'(1);
      end
    end else if (accept ? last_beat : !Req[owner]) begin
      state_n = ARB;
      ptr_n = next_idx(owner);
      beats_n = '0;
    end else if (accept) beats_n = beats + 1'b1;
    cnt_n = (accept && !pop) ? cnt + 1'b1 : (!accept && pop && cnt != '0) ? cnt - 1'b1 : cnt;
  end
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) begin
      state <= ARB;
      ptr <= '0;
      owner <= '0;
      beats <= '0;
      cnt <= '0;
      Wr_Req <= 1'b0;
      Data_in <= '0;
      Grant_Idx <= '0;
      Ovf_Err <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      owner <= owner_n;
      beats <= beats_n;
      cnt <= cnt_n;
      Wr_Req <= accept;
      if (accept) begin
        Data_in <= win_data;
        Grant_Idx <= win;
      end
      Ovf_Err <= Ovf_Err | (Wr_Req & Full);
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed and random checks of fifo_wr_arbiter against an integer-level model
module tb_fifo_wr_arbiter;
  localparam int W = 8, D = 8, N = 4, B = 4;
  logic CLK = 0, rst_n = 1;
  logic [N-1:0] Req = '0;
  logic [N*W-1:0] Data = '0;
  logic [N-1:0] Grant;
  logic [1:0] Grant_Idx;
  logic Wr_Req, Rd_Req = 0, Empty = 1, Full = 0, Ovf_Err;
  logic [W-1:0] Data_in;
  always #5 CLK = ~CLK;
  fifo_wr_arbiter #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .NUM_REQ(N), .BURST_MAX(B)) dut (
    .CLK(CLK), .rst_n(rst_n), .Req(Req), .Data(Data), .Grant(Grant), .Grant_Idx(Grant_Idx),
    .Wr_Req(Wr_Req), .Data_in(Data_in), .Rd_Req(Rd_Req), .Empty(Empty), .Full(Full), .Ovf_Err(Ovf_Err)
  );
  int vectors = 0, miscompares = 0;
  int m_own, m_ptr, m_beats, m_cnt, m_idx, m_din, occ, last_win, n;
  bit m_wr, m_ovf, last_acc, fifo_mode = 0;
  int seq[$];
  int exp_er[6] = '{1, 1, 2, 2, 2, 2};
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_own = -1; m_ptr = 0; m_beats = 0; m_cnt = 0; m_idx = 0; m_din = 0;
    m_wr = 0; m_ovf = 0; occ = 0;
  endtask
  function automatic int exp_grant();
    if (!rst_n || m_cnt >= D) return 0;
    if (m_own >= 0) return Req[m_own] ? (1 << m_own) : 0;
    for (int k = 0; k < N; k++)
      if (Req[(m_ptr + k) % N]) return 1 << ((m_ptr + k) % N);
    return 0;
  endfunction
  task automatic tick();
    int g, w;
    bit acc, pop;
    #1;
    g = exp_grant();
    chk("grant", 32'(Grant), 32'(g));
    chk("wr_req", 32'(Wr_Req), 32'(m_wr));
    chk("data_in", 32'(Data_in), 32'(m_din));
    chk("grant_idx", 32'(Grant_Idx), 32'(m_idx));
    chk("ovf_err", 32'(Ovf_Err), 32'(m_ovf));
    acc = g != 0;
    w = 0;
    for (int i = 0; i < N; i++) if (g[i]) w = i;
    pop = Rd_Req && !Empty;
    @(posedge CLK);
    if (!rst_n) model_reset();
    else begin
      if (fifo_mode) occ = occ + (m_wr ? 1 : 0) - (pop ? 1 : 0);
      m_ovf = m_ovf || (m_wr && Full);
      m_wr = acc;
      if (acc) begin
        m_din = int'((Data >> (w * W)) & 32'hFF);
        m_idx = w;
      end
      if (acc && !pop) m_cnt++;
      else if (!acc && pop && m_cnt > 0) m_cnt--;
      if (m_own < 0) begin
        if (acc) begin
          if (B == 1) m_ptr = (w + 1) % N;
          else begin m_own = w; m_beats = 1; end
        end
      end else if (acc) begin
        m_beats++;
        if (m_beats == B) begin m_ptr = (m_own + 1) % N; m_own = -1; end
      end else if (!Req[m_own]) begin
        m_ptr = (m_own + 1) % N;
        m_own = -1;
      end
    end
    last_acc = acc;
    last_win = w;
    @(negedge CLK);
    if (fifo_mode) begin
      Empty = occ == 0;
      Full = occ == D;
    end
  endtask
  task automatic do_reset();
    rst_n = 0;
    model_reset();
    Req = '0; Rd_Req = 0; Empty = 1; Full = 0;
    repeat (2) tick();
    rst_n = 1;
  endtask
  initial begin
    model_reset();
    Data = {8'h40, 8'h30, 8'h20, 8'h10};
    Req = 4'hF;
    #2 rst_n = 0;
    @(negedge CLK);
    repeat (5) tick();
    chk("rst_wr_req", 32'(Wr_Req), 0);
    chk("rst_data_in", 32'(Data_in), 0);
    chk("rst_grant", 32'(Grant), 0);
    chk("rst_ovf", 32'(Ovf_Err), 0);
    rst_n = 1;
    Rd_Req = 1; Empty = 0;
    #1 chk("first_grant", 32'(Grant), 32'h1);
    seq.delete();
    repeat (20) begin
      tick();
      if (last_acc) seq.push_back(int'((Data >> (last_win * W)) & 32'hFF));
    end
    chk("rr_len", 32'(seq.size()), 20);
    foreach (seq[k]) chk("rr_data", 32'(seq[k]), 32'((k / 4 % 4 + 1) * 16));
    do_reset();
    Req = 4'h1; Rd_Req = 0; Empty = 0;
    n = 0;
    repeat (12) begin tick(); n += int'(last_acc); end
    chk("credit_beats", 32'(n), 8);
    chk("credit_model_cnt", 32'(m_cnt), 8);
    #1 chk("credit_stall", 32'(Grant), 0);
    Rd_Req = 1;
    n = 0;
    tick();
    n += int'(last_acc);
    Rd_Req = 0;
    repeat (4) begin tick(); n += int'(last_acc); end
    chk("credit_one", 32'(n), 1);
    chk("credit_ovf", 32'(Ovf_Err), 0);
    do_reset();
    Rd_Req = 1; Empty = 0; Req = 4'b0110;
    seq.delete();
    repeat (2) begin tick(); if (last_acc) seq.push_back(last_win); end
    Req = 4'b0100;
    repeat (5) begin tick(); if (last_acc) seq.push_back(last_win); end
    chk("early_len", 32'(seq.size()), 6);
    foreach (seq[k]) if (k < 6) chk("early_idx", 32'(seq[k]), 32'(exp_er[k]));
    Req = 4'b1101;
    #1 chk("ptr3_grant", 32'(Grant), 32'h8);
    tick();
    do_reset();
    Req = 4'h1; Rd_Req = 0; Empty = 0;
    repeat (7) tick();
    chk("simul_model_cnt7", 32'(m_cnt), 7);
    Rd_Req = 1;
    tick();
    Req = 4'h0; Empty = 1;
    tick();
    chk("simul_model_hold", 32'(m_cnt), 7);
    Req = 4'h1; Rd_Req = 0; Empty = 0;
    n = 0;
    repeat (3) begin tick(); n += int'(last_acc); end
    chk("simul_one", 32'(n), 1);
    do_reset();
    Req = 4'h1; Empty = 0;
    tick();
    Full = 1;
    tick();
    Full = 0;
    #1 chk("ovf_set", 32'(Ovf_Err), 1);
    repeat (2) tick();
    chk("ovf_sticky", 32'(Ovf_Err), 1);
    do_reset();
    Req = 4'h1; Empty = 0;
    repeat (3) tick();
    Req = 4'b0100;
    repeat (3) tick();
    chk("mid_model_cnt", 32'(m_cnt), 5);
    chk("mid_model_own", 32'(m_own), 2);
    chk("mid_wr_before", 32'(Wr_Req), 1);
    #3 rst_n = 0;
    model_reset();
    #1;
    chk("mid_grant", 32'(Grant), 0);
    chk("mid_wr_req", 32'(Wr_Req), 0);
    chk("mid_data_in", 32'(Data_in), 0);
    chk("mid_grant_idx", 32'(Grant_Idx), 0);
    chk("mid_ovf", 32'(Ovf_Err), 0);
    @(negedge CLK);
    Req = 4'b1001;
    rst_n = 1;
    #1 chk("post_rst_grant", 32'(Grant), 32'h1);
    tick();
    do_reset();
    fifo_mode = 1;
    repeat (3000) begin
      logic [N-1:0] nr;
      for (int i = 0; i < N; i++) nr[i] = $urandom_range(0, 9) < 7;
      for (int i = 0; i < N; i++)
        if (!(Req[i] && nr[i])) Data[i*W +: W] = 8'($urandom);
      Req = nr;
      Rd_Req = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 0;
        model_reset();
        Empty = 1;
        Full = 0;
      end else rst_n = 1;
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
